// File: rtl/layer_compositor_if.sv
// Pixel-side bundle between the per-object renderers / display controller and the compositor.
// The master drives layer pixels and raster position; the slave returns colour and collision flags.
interface layer_compositor_if #(
  parameter int N_LAYERS = 6,
  parameter int COLOR_W  = 12,
  parameter int CNT_W    = 10
);
  logic [N_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [N_LAYERS-1:0]         layer_on;
  logic [N_LAYERS-1:0]         layer_mask;
  logic [CNT_W-1:0]            hCount;
  logic [CNT_W-1:0]            vCount;
  logic                        bright;
  logic [COLOR_W/3-1:0]        vga_r;
  logic [COLOR_W/3-1:0]        vga_g;
  logic [COLOR_W/3-1:0]        vga_b;
  logic [N_LAYERS-1:0]         collision;
  logic                        frame_done;

  modport master (
    output layer_rgb, layer_on, layer_mask, hCount, vCount, bright,
    input  vga_r, vga_g, vga_b, collision, frame_done
  );

  modport slave (
    input  layer_rgb, layer_on, layer_mask, hCount, vCount, bright,
    output vga_r, vga_g, vga_b, collision, frame_done
  );
endinterface

// File: rtl/layer_compositor.sv
// Fixed-priority N-layer pixel merge with colour key, mask and blanking, plus per-frame overlap
// flags against COLL_REF. Two-cycle latency, one pixel per cycle, never stalls.
module layer_compositor #(
  parameter int                 N_LAYERS  = 6,
  parameter int                 COLOR_W   = 12,
  parameter bit                 KEY_EN    = 1'b1,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F,
  parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h000,
  parameter int                 COLL_REF  = 0,
  parameter int                 CNT_W     = 10
) (
  input logic               clk,
  input logic               reset,
  layer_compositor_if.slave bus
);
  localparam int CH_W = COLOR_W / 3;

  logic [N_LAYERS-1:0]         vis_d, vis_q;
  logic [N_LAYERS*COLOR_W-1:0] rgb_q;
  logic                        bright_q;
  logic                        fs_d, fs_q;

  logic [COLOR_W-1:0]  pix_d;
  logic [COLOR_W-1:0]  vga_d, vga_q;
  logic [N_LAYERS-1:0] ov_d;
  logic [N_LAYERS-1:0] coll_acc_d, coll_acc_q;
  logic [N_LAYERS-1:0] collision_d, collision_q;
  logic                frame_done_d, frame_done_q;

  always_comb begin
    vis_d = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      vis_d[i] = bus.layer_on[i] & bus.layer_mask[i] &
                 ~(KEY_EN && (bus.layer_rgb[i*COLOR_W +: COLOR_W] == KEY_COLOR));
    end
    fs_d = (bus.hCount == CNT_W'(0)) && (bus.vCount == CNT_W'(0));
  end

  // Walk from lowest priority upward so the lowest visible index wins.
  always_comb begin
    pix_d = BG_COLOR;
    for (int i = N_LAYERS-1; i >= 0; i--) begin
      if (vis_q[i]) pix_d = rgb_q[i*COLOR_W +: COLOR_W];
    end
  end

  always_comb begin
    ov_d = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      ov_d[i] = (i != COLL_REF) && vis_q[i] && vis_q[COLL_REF] && bright_q;
    end
    vga_d        = bright_q ? pix_d : '0;
    // The boundary pixel seeds the new frame instead of closing the old one.
    coll_acc_d   = fs_q ? ov_d : (coll_acc_q | ov_d);
    collision_d  = fs_q ? coll_acc_q : collision_q;
    frame_done_d = fs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vis_q        <= '0;
      rgb_q        <= '0;
      bright_q     <= 1'b0;
      fs_q         <= 1'b0;
      vga_q        <= '0;
      coll_acc_q   <= '0;
      collision_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      vis_q        <= vis_d;
      rgb_q        <= bus.layer_rgb;
      bright_q     <= bus.bright;
      fs_q         <= fs_d;
      vga_q        <= vga_d;
      coll_acc_q   <= coll_acc_d;
      collision_q  <= collision_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.vga_r      = vga_q[3*CH_W-1 -: CH_W];
  assign bus.vga_g      = vga_q[2*CH_W-1 -: CH_W];
  assign bus.vga_b      = vga_q[CH_W-1:0];
  assign bus.collision  = collision_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Randomised and directed check of layer_compositor (KEY_EN=1 and KEY_EN=0 builds side by side)
// against a cycle-queue reference model derived from the compositing and collision rules.
module tb_layer_compositor;
  localparam int N = 6;
  localparam int C = 12;
  localparam int W = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [C-1:0]   rgb [N];
  logic [N*C-1:0] l_rgb;
  logic [N-1:0]   l_on = '0;
  logic [N-1:0]   l_mask = '1;
  logic [W-1:0]   hc = W'(5);
  logic [W-1:0]   vc = W'(5);
  logic           br = 1'b0;

  always_comb begin
    l_rgb = '0;
    for (int i = 0; i < N; i++) l_rgb[i*C +: C] = rgb[i];
  end

  layer_compositor_if #(.N_LAYERS(N), .COLOR_W(C), .CNT_W(W)) bus0 ();
  layer_compositor_if #(.N_LAYERS(N), .COLOR_W(C), .CNT_W(W)) bus1 ();

  assign bus0.layer_rgb  = l_rgb;
  assign bus0.layer_on   = l_on;
  assign bus0.layer_mask = l_mask;
  assign bus0.hCount     = hc;
  assign bus0.vCount     = vc;
  assign bus0.bright     = br;
  assign bus1.layer_rgb  = l_rgb;
  assign bus1.layer_on   = l_on;
  assign bus1.layer_mask = l_mask;
  assign bus1.hCount     = hc;
  assign bus1.vCount     = vc;
  assign bus1.bright     = br;

  layer_compositor #(.N_LAYERS(N), .COLOR_W(C), .KEY_EN(1'b1), .KEY_COLOR(12'hF0F),
                     .BG_COLOR(12'h000), .COLL_REF(0), .CNT_W(W))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  layer_compositor #(.N_LAYERS(N), .COLOR_W(C), .KEY_EN(1'b0), .KEY_COLOR(12'hF0F),
                     .BG_COLOR(12'h000), .COLL_REF(0), .CNT_W(W))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  typedef struct {
    logic [C-1:0] vga  [2];
    logic [N-1:0] coll [2];
    logic         fd;
  } exp_t;

  exp_t         q [$];
  logic [N-1:0] acc [2];
  logic [N-1:0] cur_coll [2];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] vis_of(input int key_en);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++)
      v[i] = l_on[i] && l_mask[i] && !(key_en != 0 && rgb[i] == 12'hF0F);
    return v;
  endfunction

  function automatic logic [C-1:0] vga0();
    return {bus0.vga_r, bus0.vga_g, bus0.vga_b};
  endfunction

  function automatic logic [C-1:0] vga1();
    return {bus1.vga_r, bus1.vga_g, bus1.vga_b};
  endfunction

  task automatic model_reset();
    exp_t z;
    q.delete();
    for (int k = 0; k < 2; k++) begin
      acc[k] = '0; cur_coll[k] = '0; z.vga[k] = '0; z.coll[k] = '0;
    end
    z.fd = 1'b0;
    q.push_back(z);
  endtask

  task automatic model_push();
    exp_t e;
    logic [N-1:0] v, ov;
    logic fs;
    fs = (hc == 0) && (vc == 0);
    for (int k = 0; k < 2; k++) begin
      v = vis_of(1 - k);
      e.vga[k] = 12'h000;
      if (br) begin
        for (int i = 0; i < N; i++) if (v[i]) begin e.vga[k] = rgb[i]; break; end
      end
      ov = (br && v[0]) ? (v & ~N'(1)) : '0;
      if (fs) begin cur_coll[k] = acc[k]; acc[k] = ov; end
      else acc[k] = acc[k] | ov;
      e.coll[k] = cur_coll[k];
    end
    e.fd = fs;
    q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    if (!reset) model_push();
    @(posedge clk); #1;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      chk("vga_key",   32'(vga0()),           32'(e.vga[0]));
      chk("vga_nokey", 32'(vga1()),           32'(e.vga[1]));
      chk("coll_key",  32'(bus0.collision),   32'(e.coll[0]));
      chk("coll_nokey",32'(bus1.collision),   32'(e.coll[1]));
      chk("fd_key",    32'(bus0.frame_done),  32'(e.fd));
      chk("fd_nokey",  32'(bus1.frame_done),  32'(e.fd));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vga",  32'(vga0()),          32'h0);
    chk("rst_coll", 32'(bus0.collision),  32'h0);
    chk("rst_fd",   32'(bus0.frame_done), 32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic px(input int h, input int v, input logic b);
    hc = W'(h); vc = W'(v); br = b;
  endtask

  initial begin
    for (int i = 0; i < N; i++) rgb[i] = 12'h000;
    do_reset();

    // Priority: lowest visible index wins.
    l_on = 6'b101000; rgb[3] = 12'h0F0; rgb[5] = 12'hF00; px(5, 5, 1'b1);
    cyc(); cyc();
    chk("prio_l3", 32'(vga0()), 32'h0F0);
    l_on[3] = 1'b0;
    cyc(); cyc();
    chk("prio_l5", 32'(vga0()), 32'hF00);

    // Colour key and mask.
    l_on = 6'b000101; rgb[0] = 12'hF0F; rgb[2] = 12'h00F;
    cyc(); cyc();
    chk("key_transp", 32'(vga0()), 32'h00F);
    chk("key_off",    32'(vga1()), 32'hF0F);
    l_mask[2] = 1'b0;
    cyc(); cyc();
    chk("mask_bg", 32'(vga0()), 32'h000);
    l_mask = '1;

    // Blanking follows bright with the same 2-cycle delay.
    px(6, 5, 1'b1); cyc(); px(7, 5, 1'b0); cyc();
    chk("blank_a", 32'(vga0()), 32'h00F);
    px(8, 5, 1'b1); cyc();
    chk("blank_b", 32'(vga0()), 32'h000);
    px(9, 5, 1'b1); cyc();
    chk("blank_c", 32'(vga0()), 32'h00F);

    // Frame k: L0/L4 overlap for 3 pixels; L0/L1 overlap only while blanked.
    l_on = '0; rgb[0] = 12'h111; rgb[1] = 12'h333; rgb[4] = 12'h222;
    px(0, 0, 1'b1); cyc();
    l_on = 6'b010001;
    for (int h = 1; h <= 3; h++) begin px(h, 0, 1'b1); cyc(); end
    l_on = 6'b000011; px(4, 0, 1'b0); cyc();
    l_on = '0;
    for (int h = 5; h <= 8; h++) begin px(h, 0, 1'b1); cyc(); end
    px(0, 0, 1'b1); cyc(); px(1, 0, 1'b1); cyc();
    chk("coll_k", 32'(bus0.collision), 32'h10);
    chk("fd_k",   32'(bus0.frame_done), 32'h1);
    px(2, 0, 1'b1); cyc();
    chk("fd_pulse", 32'(bus0.frame_done), 32'h0);
    for (int h = 3; h <= 6; h++) begin px(h, 0, 1'b1); cyc(); end

    // Frame k+1 had no overlap; this boundary pixel overlaps and seeds the next frame.
    l_on = 6'b010001; px(0, 0, 1'b1); cyc();
    l_on = '0; px(1, 0, 1'b1); cyc();
    chk("coll_k1", 32'(bus0.collision), 32'h0);
    for (int h = 2; h <= 6; h++) begin px(h, 0, 1'b1); cyc(); end
    px(0, 0, 1'b1); cyc(); px(1, 0, 1'b1); cyc();
    chk("coll_bnd", 32'(bus0.collision), 32'h10);

    // Held hCount=vCount=0: each cycle is a boundary reporting one pixel.
    l_on = 6'b010001; px(0, 0, 1'b1); cyc(); cyc();
    l_on = '0; cyc(); cyc();
    chk("coll_hold", 32'(bus0.collision), 32'h10);

    // Reset mid-frame discards the partial accumulation.
    px(0, 0, 1'b1); cyc();
    l_on = 6'b010001; px(10, 100, 1'b1); cyc(); cyc();
    l_on = '0; px(5, 200, 1'b1); cyc();
    do_reset();
    for (int h = 5; h <= 8; h++) begin px(h, 300, 1'b1); cyc(); end
    px(0, 0, 1'b1); cyc(); px(1, 0, 1'b1); cyc();
    chk("coll_rst", 32'(bus0.collision), 32'h0);
    chk("fd_rst",   32'(bus0.frame_done), 32'h1);

    // Random traffic with frequent frame boundaries.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        rgb[i] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom_range(0, 4095));
      l_on   = N'($urandom_range(0, 63));
      l_mask = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 63)) : '1;
      px(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
